// File: rtl/shift_unit_pkg.sv
// Shared types for the pipelined shifter: OP encodings, stage payload, layer split helper.
package shift_pkg;

    localparam int unsigned MAX_WIDTH   = 64;
    localparam int unsigned MAX_SHAMT_W = 6;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_ROTR = 2'b11
    } shift_op_t;

    // Sized for the widest build; narrower builds use the low bits only.
    typedef struct packed {
        logic [MAX_WIDTH-1:0]   data;
        logic [MAX_SHAMT_W-1:0] shamt;
        shift_op_t              op;
        logic                   sign;
    } shift_payload_t;

    function automatic int unsigned layers_per_stage(input int unsigned shamt_w,
                                                     input int unsigned stages);
        return (shamt_w + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/shift_unit_stage.sv
// One pipeline stage: mux layers LAYER_LO..LAYER_HI-1 followed by the valid/payload register.
// Rotate wrap-around path is built only when SHIFT_UNIT_ROTATE_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SHAMT_W  = 5,
    parameter int unsigned LAYER_LO = 0,
    parameter int unsigned LAYER_HI = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  shift_payload_t in_payload,
    output logic           out_valid,
    input  logic           out_ready,
    output shift_payload_t out_payload
);

    function automatic logic [WIDTH-1:0] shift_layer(input logic [WIDTH-1:0] d,
                                                     input shift_op_t        op,
                                                     input logic             sign,
                                                     input int unsigned      amt);
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] res;
        fill = ~({WIDTH{1'b1}} >> amt);
        case (op)
            SHIFT_SLL: res = d << amt;
            SHIFT_SRA: res = (d >> amt) | (sign ? fill : '0);
`ifdef SHIFT_UNIT_ROTATE_EN
            SHIFT_ROTR: res = (d >> amt) | (d << (WIDTH - amt));
`endif
            default:   res = d >> amt;
        endcase
        return res;
    endfunction

    logic           load;
    logic           valid_q;
    shift_payload_t payload_q;
    shift_payload_t shifted;
    logic [WIDTH-1:0] d;

    assign load     = !valid_q || out_ready;
    assign in_ready = load;

    always_comb begin
        d = in_payload.data[WIDTH-1:0];
        for (int unsigned k = 0; k < SHAMT_W; k++) begin
            if (k >= LAYER_LO && k < LAYER_HI && in_payload.shamt[k])
                d = shift_layer(d, in_payload.op, in_payload.sign, 32'd1 << k);
        end
        shifted = in_payload;
        shifted.data = '0;
        shifted.data[WIDTH-1:0] = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load) begin
            valid_q <= in_valid;
            if (in_valid)
                payload_q <= shifted;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;

endmodule

// File: rtl/shift_unit.sv
// Pipelined SLL/SRL/SRA/ROTR shifter with valid/ready on both sides.
// Define SHIFT_UNIT_ROTATE_EN to enable ROTR; otherwise OP=11 acts as SRL.
module shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   SHIFT_IN,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic [1:0]         OP,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [WIDTH-1:0]   SHIFT_OUT
);

    localparam int unsigned LPS = layers_per_stage(SHAMT_W, STAGES);

    shift_payload_t payload [0:STAGES];
    logic           valid   [0:STAGES];
    logic           ready   [0:STAGES];

    always_comb begin
        payload[0]                    = '0;
        payload[0].data[WIDTH-1:0]    = SHIFT_IN;
        payload[0].shamt[SHAMT_W-1:0] = SHAMT;
        payload[0].op                 = shift_op_t'(OP);
        payload[0].sign               = SHIFT_IN[WIDTH-1];
    end

    assign valid[0]      = IN_VALID;
    assign ready[STAGES] = OUT_READY;
    assign IN_READY      = ready[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned LO = int'(s) * LPS;
        localparam int unsigned HI = (LO + LPS > SHAMT_W) ? SHAMT_W : LO + LPS;

        shift_stage #(
            .WIDTH    (WIDTH),
            .SHAMT_W  (SHAMT_W),
            .LAYER_LO (LO),
            .LAYER_HI (HI)
        ) u_stage (
            .clk         (CLK),
            .reset       (RESET),
            .in_valid    (valid[s]),
            .in_ready    (ready[s]),
            .in_payload  (payload[s]),
            .out_valid   (valid[s+1]),
            .out_ready   (ready[s+1]),
            .out_payload (payload[s+1])
        );
    end

    assign OUT_VALID = valid[STAGES];
    assign SHIFT_OUT = payload[STAGES].data[WIDTH-1:0];

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: directed spec cases, backpressure, reset flush, random traffic.
module tb_shift_unit;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned STAGES  = 2;
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               IN_VALID = 1'b0;
    logic               IN_READY;
    logic [WIDTH-1:0]   SHIFT_IN = '0;
    logic [SHAMT_W-1:0] SHAMT = '0;
    logic [1:0]         OP = '0;
    logic               OUT_VALID;
    logic               OUT_READY = 1'b1;
    logic [WIDTH-1:0]   SHIFT_OUT;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] sb[$];
    bit   ready_random = 1'b0;
    bit   ready_force  = 1'b1;

    shift_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .SHIFT_IN  (SHIFT_IN),
        .SHAMT     (SHAMT),
        .OP        (OP),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SHIFT_OUT (SHIFT_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [WIDTH-1:0] model(input logic [1:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input int unsigned n);
        logic [2*WIDTH-1:0] dbl;
        case (op)
            2'b00: return x << n;
            2'b10: return WIDTH'($signed(x) >>> n);
`ifdef SHIFT_UNIT_ROTATE_EN
            2'b11: begin
                dbl = {x, x} >> n;
                return dbl[WIDTH-1:0];
            end
`endif
            default: return x >> n;
        endcase
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always begin
        @(posedge CLK);
        #1;
        OUT_READY = ready_random ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Monitor: pops on every output transfer, checks hold while stalled.
    logic [WIDTH-1:0] held_val;
    bit               held = 1'b0;
    always @(negedge CLK) begin
        if (RESET) begin
            held = 1'b0;
        end else begin
            if (held && OUT_VALID)
                check("stall_hold", SHIFT_OUT, held_val);
            held = 1'b0;
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got 0x%08h expected no output", SHIFT_OUT);
                end else begin
                    check("result", SHIFT_OUT, sb.pop_front());
                end
            end else if (OUT_VALID) begin
                held     = 1'b1;
                held_val = SHIFT_OUT;
            end
        end
    end

    // Called right after a rising edge (+1); returns #1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] x, input int unsigned n,
                        input logic [1:0] op, input logic [WIDTH-1:0] exp);
        int unsigned waited = 0;
        SHIFT_IN = x;
        SHAMT    = SHAMT_W'(n);
        OP       = op;
        IN_VALID = 1'b1;
        forever begin
            @(negedge CLK);
            if (IN_READY) begin
                sb.push_back(exp);
                @(posedge CLK);
                #1;
                IN_VALID = 1'b0;
                SHIFT_IN = $urandom;
                SHAMT    = SHAMT_W'($urandom);
                return;
            end
            waited++;
            if (waited > 200) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: got IN_READY=0 expected 1");
                IN_VALID = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain();
        int unsigned cyc = 0;
        while (sb.size() != 0 && cyc < 1000) begin
            @(posedge CLK);
            cyc++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        #1;
    endtask

    initial begin
        int unsigned lat;
        logic [WIDTH-1:0] rot_exp;

        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_out_valid", WIDTH'(OUT_VALID), '0);
        check("reset_in_ready", WIDTH'(IN_READY), 1);
        check("reset_shift_out", SHIFT_OUT, '0);
        @(posedge CLK);
        #1;

        // Latency and single-cycle OUT_VALID.
        send(32'h0000_0001, 2, 2'b00, 32'h0000_0004);
        lat = 1;
        @(negedge CLK);
        while (!OUT_VALID && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("latency", WIDTH'(lat), WIDTH'(STAGES));
        @(negedge CLK);
        check("valid_one_cycle", WIDTH'(OUT_VALID), '0);
        @(posedge CLK);
        #1;

        send(32'h8000_0000, 4, 2'b10, 32'hF800_0000);
        send(32'h8000_0000, 31, 2'b01, 32'h0000_0001);
        for (int op = 0; op < 4; op++)
            send(32'hDEAD_BEEF, 0, 2'(op), 32'hDEAD_BEEF);
`ifdef SHIFT_UNIT_ROTATE_EN
        rot_exp = 32'h1000_000F;
`else
        rot_exp = 32'h0000_000F;
`endif
        send(32'h0000_00F1, 4, 2'b11, rot_exp);
        drain();

        // Backpressure ordering.
        ready_force = 1'b0;
        @(posedge CLK);
        #1;
        fork
            begin
                send(32'h1, 1, 2'b00, 32'h2);
                send(32'h1, 2, 2'b00, 32'h4);
                @(negedge CLK);
                check("in_ready_stalled", WIDTH'(IN_READY), '0);
                send(32'h1, 3, 2'b00, 32'h8);
                send(32'h1, 4, 2'b00, 32'h10);
                send(32'h1, 5, 2'b00, 32'h20);
            end
            begin
                repeat (4) @(posedge CLK);
                ready_force = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight.
        ready_force = 1'b0;
        @(posedge CLK);
        #1;
        send(32'h1234_5678, 1, 2'b00, 32'h2468_ACF0);
        send(32'h1234_5678, 4, 2'b01, 32'h0123_4567);
        RESET = 1'b1;
        sb.delete();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        ready_force = 1'b1;
        @(negedge CLK);
        check("flush_out_valid", WIDTH'(OUT_VALID), '0);
        check("flush_in_ready", WIDTH'(IN_READY), 1);
        repeat (5) @(posedge CLK);
        #1;

        // Random traffic with random backpressure.
        ready_random = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            logic [WIDTH-1:0] x;
            int unsigned      n;
            logic [1:0]       op;
            x  = $urandom;
            n  = $urandom_range(0, WIDTH - 1);
            op = 2'($urandom);
            send(x, n, op, model(op, x, n));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end
        ready_random = 1'b0;
        ready_force  = 1'b1;
        drain();
        repeat (3) @(posedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
